// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle restoring divider producing one quotient bit per
//            clock. Supports a per-operation signed/unsigned mode, detects
//            divide-by-zero and uses a start/busy/done handshake.
// Ports    : clk            - system clock, rising edge
//            reset_n        - synchronous active-low reset
//            i_start        - operation request, accepted only while idle
//            i_signed_mode  - 1: operands are two's complement (sampled w/ start)
//            i_a / i_b      - dividend / divisor (sampled with start)
//            o_busy         - high from the cycle after acceptance to done (incl.)
//            o_done         - one-cycle pulse, results valid
//            o_q / o_r      - quotient / remainder, held until next accepted start
//            o_div_by_zero  - divisor was zero, held with o_q/o_r
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_signed_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r,
    output logic             o_div_by_zero
);

    localparam int               c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0]  c_CNT_INIT = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_r;
    logic              r_dbz;
    logic [WIDTH-1:0]  r_work;    // partial remainder
    logic [WIDTH-1:0]  r_dvd;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]  r_dvs;     // divisor magnitude
    logic [c_CW-1:0]   r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_mode;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic              w_b_zero;
    logic [WIDTH+1:0]  w_trial;
    logic              w_trial_neg;
    logic [WIDTH-1:0]  w_q_fix;
    logic [WIDTH-1:0]  w_r_fix;

    // Operand conditioning at acceptance. The magnitude of MIN is MIN itself,
    // which is the correct unsigned value 2^(WIDTH-1).
    assign w_mode   = i_signed_mode & SIGNED_EN;
    assign w_a_neg  = w_mode & i_a[WIDTH-1];
    assign w_b_neg  = w_mode & i_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~i_a + c_ONE) : i_a;
    assign w_b_mag  = w_b_neg ? (~i_b + c_ONE) : i_b;
    assign w_b_zero = (i_b == '0);

    // Trial subtraction carries two extra bits so the top bit is a clean
    // borrow flag; the partial remainder never exceeds WIDTH bits afterwards.
    assign w_trial     = {1'b0, r_work, r_dvd[WIDTH-1]} - {2'b00, r_dvs};
    assign w_trial_neg = w_trial[WIDTH+1];

    // Truncating-division sign fix-up: quotient negative iff operand signs
    // differ, remainder follows the dividend.
    assign w_q_fix = r_neg_q ? (~r_dvd + c_ONE) : r_dvd;
    assign w_r_fix = r_neg_r ? (~r_work + c_ONE) : r_work;

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = w_b_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                o_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                o_busy      = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
            r_work  <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dbz <= w_b_zero;
                        if (w_b_zero) begin
                            // Results are known immediately; identical in both modes.
                            r_q <= '1;
                            r_r <= i_a;
                        end else begin
                            r_work  <= '0;
                            r_dvd   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_cnt   <= c_CNT_INIT;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                S_CALC: begin
                    if (!w_trial_neg) begin
                        r_work <= w_trial[WIDTH-1:0];
                        r_dvd  <= {r_dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        r_work <= {r_work[WIDTH-2:0], r_dvd[WIDTH-1]};
                        r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
                S_FIX: begin
                    r_q <= w_q_fix;
                    r_r <= w_r_fix;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_q           = r_q;
    assign o_r           = r_r;
    assign o_div_by_zero = r_dbz;

endmodule
`default_nettype wire
